// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage read-modify-write controller:
// FSM state encoding, RISC-V load/store funct3 codes and access legality.
package mem_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_WRITE = 3'd3,
    ST_RESP  = 3'd4
  } state_t;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  // Illegal funct3 or misaligned access; such requests never touch memory.
  function automatic logic access_err(input logic       store,
                                      input logic [2:0] func3,
                                      input logic [1:0] addr_lo);
    logic err;
    err = 1'b0;
    if (func3 == 3'b011 || func3 == 3'b110 || func3 == 3'b111) err = 1'b1;
    if (store && func3[2]) err = 1'b1;
    if (func3[1:0] == 2'b01 && addr_lo[0]) err = 1'b1;
    if (func3[1:0] == 2'b10 && addr_lo != 2'b00) err = 1'b1;
    return err;
  endfunction

endpackage

// File: rtl/mem_rmw_ctrl_ld_st_type.sv
// Byte-lane unit: merges store data into a memory word and extracts/extends
// load data from a memory word, both steered by funct3 and addr[1:0].
module LD_ST_type
  import mem_pkg::*;
(
  input  logic [2:0]  func3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] st_data_i,
  input  logic [31:0] st_word_i,
  input  logic [31:0] ld_word_i,
  output logic [31:0] st_merged_o,
  output logic [31:0] ld_data_o
);

  logic [31:0] lane_mask;
  logic [31:0] lane_data;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Replicate store data across lanes and replace only the addressed lane(s).
  always_comb begin
    lane_mask = '0;
    lane_data = '0;
    case (func3_i[1:0])
      SB[1:0]: begin
        lane_data = {4{st_data_i[7:0]}};
        case (addr_lo_i)
          2'd0:    lane_mask = 32'h0000_00FF;
          2'd1:    lane_mask = 32'h0000_FF00;
          2'd2:    lane_mask = 32'h00FF_0000;
          default: lane_mask = 32'hFF00_0000;
        endcase
      end
      SH[1:0]: begin
        lane_data = {2{st_data_i[15:0]}};
        lane_mask = addr_lo_i[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
      end
      default: begin
        lane_data = st_data_i;
        lane_mask = '1;
      end
    endcase
    st_merged_o = (st_word_i & ~lane_mask) | (lane_data & lane_mask);
  end

  // Select the addressed byte/half of the loaded word and extend it.
  always_comb begin
    case (addr_lo_i)
      2'd0:    ld_byte = ld_word_i[7:0];
      2'd1:    ld_byte = ld_word_i[15:8];
      2'd2:    ld_byte = ld_word_i[23:16];
      default: ld_byte = ld_word_i[31:24];
    endcase
    ld_half = addr_lo_i[1] ? ld_word_i[31:16] : ld_word_i[15:0];
    case (func3_i)
      LB:      ld_data_o = {{24{ld_byte[7]}}, ld_byte};
      LH:      ld_data_o = {{16{ld_half[15]}}, ld_half};
      LW:      ld_data_o = ld_word_i;
      LBU:     ld_data_o = {24'h0, ld_byte};
      LHU:     ld_data_o = {16'h0, ld_half};
      default: ld_data_o = '0;
    endcase
  end

endmodule

// File: rtl/mem_rmw_ctrl.sv
// MEM-stage load/store controller for a word-wide memory. Loads read one
// word, sub-word stores do read-modify-write, sw writes directly, and
// illegal/misaligned accesses answer with an error without touching memory.
module mem_rmw_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_func3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  state_t            state_q;
  logic              store_q;
  logic [2:0]        func3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       word_q;
  logic              mem_re_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              resp_valid_q;
  logic              resp_err_q;
  logic [31:0]       resp_rdata_q;
  logic [31:0]       merged_w;
  logic [31:0]       ld_ext_w;

  LD_ST_type u_lane (
    .func3_i     (func3_q),
    .addr_lo_i   (addr_q[1:0]),
    .st_data_i   (wdata_q),
    .st_word_i   (word_q),
    .ld_word_i   (mem_rdata),
    .st_merged_o (merged_w),
    .ld_data_o   (ld_ext_w)
  );

  // Request/response sequencing with registered strobes, address and response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      store_q      <= 1'b0;
      func3_q      <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      word_q       <= '0;
      mem_re_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            store_q <= req_store;
            func3_q <= req_func3;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            if (access_err(req_store, req_func3, req_addr[1:0])) begin
              state_q      <= ST_RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_rdata_q <= '0;
            end else if (req_store && req_func3 == SW) begin
              state_q    <= ST_WRITE;
              mem_we_q   <= 1'b1;
              mem_addr_q <= {req_addr[ADDR_W-1:2], 2'b00};
            end else begin
              state_q    <= ST_READ;
              mem_re_q   <= 1'b1;
              mem_addr_q <= {req_addr[ADDR_W-1:2], 2'b00};
            end
          end
        end
        ST_READ: begin
          state_q    <= ST_WAIT;
          mem_re_q   <= 1'b0;
          mem_addr_q <= '0;
        end
        ST_WAIT: begin
          word_q <= mem_rdata;
          if (store_q) begin
            state_q    <= ST_WRITE;
            mem_we_q   <= 1'b1;
            mem_addr_q <= {addr_q[ADDR_W-1:2], 2'b00};
          end else begin
            state_q      <= ST_RESP;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= ld_ext_w;
          end
        end
        ST_WRITE: begin
          state_q      <= ST_RESP;
          mem_we_q     <= 1'b0;
          mem_addr_q   <= '0;
          resp_valid_q <= 1'b1;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= '0;
        end
        ST_RESP: begin
          if (resp_ready) begin
            state_q      <= ST_IDLE;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign mem_re     = mem_re_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  // Merge is taken from the captured word during WRITE; gated by state so the
  // bus reads zero elsewhere and drops with reset together with mem_we.
  assign mem_wdata  = (state_q == ST_WRITE) ? merged_w : '0;

endmodule

// File: tb/tb_mem_rmw_ctrl.sv
// Scoreboard bench for mem_rmw_ctrl with a word-addressed memory model.
module tb_mem_rmw_ctrl;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_store;
  logic [2:0]  req_func3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_re, mem_we;

  mem_rmw_ctrl #(.ADDR_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_store  (req_store),
    .req_func3  (req_func3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_addr   (mem_addr),
    .mem_re     (mem_re),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  int resp_done = 0;
  logic [31:0] exp_raddr = '0;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          lat;
    int          cyc0;
    int          rd0;
    int          wr0;
    int          rds;
    int          wrs;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  exp_t exp_q[$];
  wr_t  wr_q[$];

  // Memory model: read data valid the cycle after mem_re.
  logic [31:0] mem [0:255];
  always @(posedge clk) begin
    cyc++;
    if (mem_re) mem_rdata <= mem[mem_addr[9:2]];
    if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Memory-side monitor.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_re) begin
        rd_cnt++;
        chk("mem_raddr", mem_addr, exp_raddr);
      end
      if (mem_we) begin
        wr_t w;
        wr_cnt++;
        if (wr_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write: addr %h data %h", mem_addr, mem_wdata);
        end else begin
          w = wr_q.pop_front();
          chk("mem_waddr", mem_addr, w.addr);
          chk("mem_wdata", mem_wdata, w.data);
        end
      end
      if (!mem_re && !mem_we) chk("mem_addr_idle", mem_addr, 32'h0);
    end
  end

  // Response monitor.
  logic        in_resp = 1'b0;
  logic [31:0] cap_rd;
  logic        cap_err;
  always @(negedge clk) begin
    if (!rst_n) begin
      in_resp = 1'b0;
    end else if (resp_valid) begin
      chk("ready_in_resp", {31'h0, req_ready}, 32'h0);
      if (!in_resp) begin
        exp_t e;
        in_resp = 1'b1;
        cap_rd  = resp_rdata;
        cap_err = resp_err;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_resp: rdata %h err %0d", resp_rdata, resp_err);
        end else begin
          e = exp_q.pop_front();
          chk("resp_rdata", resp_rdata, e.rd);
          chk("resp_err", {31'h0, resp_err}, {31'h0, e.err});
          chk("latency", cyc - e.cyc0, e.lat);
          chk("read_count", rd_cnt - e.rd0, e.rds);
          chk("write_count", wr_cnt - e.wr0, e.wrs);
        end
      end else begin
        chk("hold_rdata", resp_rdata, cap_rd);
        chk("hold_err", {31'h0, resp_err}, {31'h0, cap_err});
      end
    end else if (in_resp) begin
      in_resp = 1'b0;
      chk("idle_after_resp", {31'h0, req_ready}, 32'h1);
      resp_done++;
    end
  end

  task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err,
                        input int lat, input int rds, input logic [31:0] exp_wd, input int wrs,
                        input int hold);
    exp_t e;
    int   n;
    int   start;
    @(negedge clk);
    if (hold > 0) resp_ready = 1'b0;
    req_valid = 1'b1; req_store = st; req_func3 = f3; req_addr = a; req_wdata = wd;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL req_ready_timeout: got 0 expected 1");
    end
    exp_raddr = {a[31:2], 2'b00};
    e.rd = exp_rd; e.err = exp_err; e.lat = lat; e.cyc0 = cyc;
    e.rd0 = rd_cnt; e.wr0 = wr_cnt; e.rds = rds; e.wrs = wrs;
    exp_q.push_back(e);
    if (wrs > 0) wr_q.push_back('{addr: {a[31:2], 2'b00}, data: exp_wd});
    start = resp_done;
    @(posedge clk);
    #1 req_valid = 1'b0;
    if (hold > 0) begin
      n = 0;
      while (!resp_valid && n < 20) begin @(negedge clk); n++; end
      repeat (hold) @(negedge clk);
      resp_ready = 1'b1;
    end
    n = 0;
    while (resp_done == start && n < 60) begin @(negedge clk); n++; end
    if (resp_done == start) begin
      checks++; errors++;
      $display("FAIL resp_timeout: got no response expected one");
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_mem_re"},     {31'h0, mem_re},     32'h0);
    chk({tag, "_mem_we"},     {31'h0, mem_we},     32'h0);
    chk({tag, "_resp_valid"}, {31'h0, resp_valid}, 32'h0);
    chk({tag, "_resp_err"},   {31'h0, resp_err},   32'h0);
    chk({tag, "_resp_rdata"}, resp_rdata,          32'h0);
    chk({tag, "_mem_addr"},   mem_addr,            32'h0);
    chk({tag, "_mem_wdata"},  mem_wdata,           32'h0);
    chk({tag, "_req_ready"},  {31'h0, req_ready},  32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[8'h40] = 32'h80FF_7F01;
    mem[8'h80] = 32'h1122_3344;
    mem_rdata = '0;
    rst_n = 1'b0; req_valid = 1'b0; req_store = 1'b0; req_func3 = '0;
    req_addr = '0; req_wdata = '0; resp_ready = 1'b1;
    #12 chk_reset_outputs("reset");
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); chk("ready_after_reset", {31'h0, req_ready}, 32'h1);

    // loads: store, f3, addr, wdata, rdata, err, lat, reads, wdata_exp, writes, hold
    do_req(1'b0, LB,  32'h103, 32'h0, 32'hFFFF_FF80, 1'b0, 3, 1, 32'h0, 0, 0);
    do_req(1'b0, LBU, 32'h103, 32'h0, 32'h0000_0080, 1'b0, 3, 1, 32'h0, 0, 0);
    do_req(1'b0, LH,  32'h102, 32'h0, 32'hFFFF_80FF, 1'b0, 3, 1, 32'h0, 0, 0);
    do_req(1'b0, LHU, 32'h100, 32'h0, 32'h0000_7F01, 1'b0, 3, 1, 32'h0, 0, 0);
    do_req(1'b0, LB,  32'h100, 32'h0, 32'h0000_0001, 1'b0, 3, 1, 32'h0, 0, 0);
    do_req(1'b0, LW,  32'h100, 32'h0, 32'h80FF_7F01, 1'b0, 3, 1, 32'h0, 0, 0);
    // read-modify-write stores and direct word store
    do_req(1'b1, SB,  32'h201, 32'h1234_56AB, 32'h0, 1'b0, 4, 1, 32'h1122_AB44, 1, 0);
    do_req(1'b0, LW,  32'h200, 32'h0, 32'h1122_AB44, 1'b0, 3, 1, 32'h0, 0, 0);
    do_req(1'b1, SH,  32'h202, 32'h0000_BEEF, 32'h0, 1'b0, 4, 1, 32'hBEEF_AB44, 1, 0);
    do_req(1'b0, LW,  32'h200, 32'h0, 32'hBEEF_AB44, 1'b0, 3, 1, 32'h0, 0, 0);
    do_req(1'b1, SW,  32'h040, 32'hDEAD_BEEF, 32'h0, 1'b0, 2, 0, 32'hDEAD_BEEF, 1, 0);
    do_req(1'b0, LW,  32'h040, 32'h0, 32'hDEAD_BEEF, 1'b0, 3, 1, 32'h0, 0, 0);
    // illegal and misaligned accesses
    do_req(1'b1, SH,     32'h003, 32'h0, 32'h0, 1'b1, 1, 0, 32'h0, 0, 0);
    do_req(1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 1'b1, 1, 0, 32'h0, 0, 0);
    do_req(1'b0, 3'b110, 32'h100, 32'h0, 32'h0, 1'b1, 1, 0, 32'h0, 0, 0);
    do_req(1'b1, 3'b100, 32'h100, 32'h0, 32'h0, 1'b1, 1, 0, 32'h0, 0, 0);
    do_req(1'b0, LW,     32'h102, 32'h0, 32'h0, 1'b1, 1, 0, 32'h0, 0, 0);
    do_req(1'b0, LHU,    32'h101, 32'h0, 32'h0, 1'b1, 1, 0, 32'h0, 0, 0);
    do_req(1'b1, SW,     32'h041, 32'h0, 32'h0, 1'b1, 1, 0, 32'h0, 0, 0);
    // backpressure: response held for 5 cycles
    do_req(1'b0, LB,  32'h041, 32'h0, 32'hFFFF_FFBE, 1'b0, 3, 1, 32'h0, 0, 5);

    // reset during WAIT of an sh: write must never happen
    @(negedge clk);
    req_valid = 1'b1; req_store = 1'b1; req_func3 = SH;
    req_addr = 32'h100; req_wdata = 32'h0000_5555;
    exp_raddr = 32'h100;
    @(posedge clk);
    #1 req_valid = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!mem_re && n < 10);
    chk("rmw_read_seen", {31'h0, mem_re}, 32'h1);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 chk_reset_outputs("mid_rmw");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); chk("ready_after_rmw_reset", {31'h0, req_ready}, 32'h1);
    repeat (4) @(negedge clk);
    chk("mem_unchanged_model", mem[8'h40], 32'h80FF_7F01);
    do_req(1'b0, LW, 32'h100, 32'h0, 32'h80FF_7F01, 1'b0, 3, 1, 32'h0, 0, 0);

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0 || wr_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL leftover_expectations: got %0d/%0d expected 0/0", exp_q.size(), wr_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_rmw_ctrl.md
MEM_RMW_CTRL -- requirements
Module: mem_rmw_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning the request and memory address width.
REQ-002 SHALL have one clock, and its reset SHALL be asynchronous and active-low.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n, input, 1, the asynchronous active-low reset.
REQ-005 SHALL have these request-side ports:
- req_valid, input, 1, MEM-stage access request.
- req_ready, output, 1, request accepted.
- req_store, input, 1, 1 = store, 0 = load.
- req_func3, input, 3, RISC-V funct3.
- req_addr, input, ADDR_W, byte address.
- req_wdata, input, 32, store data, right-aligned.
REQ-006 SHALL have these response-side ports:
- resp_valid, output, 1, response available.
- resp_ready, input, 1, response consumed.
- resp_rdata, output, 32, extended load data (0 for stores).
- resp_err, output, 1, misaligned or illegal access.
REQ-007 SHALL have these memory-side ports:
- mem_addr, output, ADDR_W, word address, bits [1:0] = 0.
- mem_re, output, 1, read strobe.
- mem_we, output, 1, write strobe.
- mem_wdata, output, 32, full merged word.
- mem_rdata, input, 32, valid the cycle after mem_re.

Function
REQ-008 SHALL implement FSM states IDLE, READ, WAIT, WRITE, RESP.
REQ-009 SHALL assert req_ready only in IDLE.
REQ-010 SHALL latch store flag, func3, address and data on req_valid & req_ready.
REQ-011 SHALL classify as error, with no memory access, any of the following, and go IDLE -> RESP with resp_err = 1:
- func3 in {011, 110, 111};
- store with func3[2] = 1;
- lh/lhu/sh with addr[0] = 1;
- lw/sw with addr[1:0] != 0.
REQ-012 SHALL sequence a load as IDLE -> READ -> WAIT -> RESP, with mem_re = 1 in READ only.
REQ-013 SHALL sequence sb/sh as a read-modify-write: IDLE -> READ -> WAIT -> WRITE -> RESP.
REQ-014 SHALL sequence sw as IDLE -> WRITE -> RESP, with no read.
REQ-015 SHALL capture mem_rdata into an internal word register in WAIT.
REQ-016 SHALL replicate store data into lanes: byte to all 4 lanes (sb), half to both halves (sh).
REQ-017 SHALL, in WRITE, assert mem_we = 1 for exactly one cycle with mem_wdata = captured word with only the addressed byte or half replaced, or req_wdata for sw.
REQ-018 SHALL, in WAIT, register load data selected by addr[1:0] and extend it: sign-extend for lb/lh, zero-extend for lbu/lhu, pass through for lw.
REQ-019 SHALL hold resp_valid, resp_rdata and resp_err stable in RESP until resp_ready, then go RESP -> IDLE.
REQ-020 SHALL NOT accept a new request in the cycle RESP exits.
REQ-021 SHALL drive mem_addr = {latched addr[ADDR_W-1:2], 2'b00} in READ and WRITE, and 0 elsewhere.
REQ-022 SHALL drive mem_re, mem_we and resp_valid low in every state not listed above.
REQ-023 SHALL have latency from accept to resp_valid of: load 3, sb/sh 4, sw 2, error 1 cycles.

Reset
REQ-024 SHALL, on rst_n low, immediately (asynchronously) force the state to IDLE.
REQ-025 SHALL, on rst_n low, force mem_re = 0, mem_we = 0, resp_valid = 0, resp_err = 0, resp_rdata = 0, mem_addr = 0, mem_wdata = 0, and all latched registers to 0.
REQ-026 SHALL, if reset asserts mid-RMW, abandon the write: mem_we drops the same instant and no partial word is written afterwards.
REQ-027 SHALL have req_ready = 1 in the first cycle after rst_n deasserts.

Structure
REQ-028 SHALL take state encodings and funct3 constants (LB, LH, LW, LBU, LHU, SB, SH, SW) from a shared package mem_pkg.
REQ-029 SHALL instantiate the existing byte-lane merge/extract unit LD_ST_type as its only sub-module, to compute merged store data and extended load data.

Verification
REQ-030 SHALL cover lb: mem word 0x80FF_7F01, addr 0x103 -> resp_rdata 0xFFFF_FF80, 3 cycles, one mem_re, no mem_we.
REQ-031 SHALL cover sb: mem word 0x1122_3344, addr 0x201, data 0xAB -> one mem_we with mem_wdata 0x1122_AB44 at mem_addr 0x200, resp after 4 cycles.
REQ-032 SHALL cover sh misaligned: addr 0x3, func3 001 -> resp_err = 1 after 1 cycle, mem_re = mem_we = 0 throughout.
REQ-033 SHALL cover sw: addr 0x40, data 0xDEAD_BEEF -> no read, mem_we with 0xDEAD_BEEF, resp after 2 cycles.
REQ-034 SHALL cover backpressure: resp_ready held 0 for 5 cycles -> outputs stable and req_ready = 0 until release, then IDLE.
REQ-035 SHALL cover reset in WAIT of an sh -> no mem_we ever, req_ready = 1 after release, memory unchanged.
